// File: rtl/mdlu_sequencer.sv
// mdlu_sequencer: multi-cycle multiply/divide controller for the execute stage.
// Runs radix-2 shift-add MULT/MULTU and restoring DIV/DIVU, stalls the pipe
// while busy, then pulses hiLoWrite with the HI/LO results.
// Ports: clk, reset (async, active-low), start, op[1:0] (00 MULT, 01 MULTU,
//   10 DIV, 11 DIVU), operandA/operandB, flush (sync abort) ->
//   busy, stall, done, hiLoWrite, hiOut, loOut, divByZero.
// Build option: MDSEQ_EARLY_OUT_EN lets zero-operand multiplies and
//   divide-by-zero go straight from IDLE to DONE.
module mdlu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             hiLoWrite,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut,
    output logic             divByZero
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} stateT;

    stateT state, nextState;

    logic [1:0]         opReg;
    logic [WIDTH-1:0]   aMag, bMag, aRaw;
    logic               signA, signB, bZero;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;

    logic               aNeg, bNeg, accept, earlyOut, writeRes;
    logic [WIDTH-1:0]   magA, magB;

    // Sign handling only applies to the signed ops (op[0]==0).
    assign aNeg = ~op[0] & operandA[WIDTH-1];
    assign bNeg = ~op[0] & operandB[WIDTH-1];
    assign magA = aNeg ? -operandA : operandA;
    assign magB = bNeg ? -operandB : operandB;

    assign accept = (state == IDLE) & start & ~flush;

`ifdef MDSEQ_EARLY_OUT_EN
    assign earlyOut = op[1] ? (operandB == '0)
                            : ((operandA == '0) | (operandB == '0));
`else
    assign earlyOut = 1'b0;
`endif

    assign busy      = (state == RUN) | (state == FIX);
    assign stall     = busy | accept;
    assign done      = (state == DONE);
    assign hiLoWrite = done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nextState;
    end

    always_comb begin
        nextState = state;
        writeRes  = 1'b0;
        unique case (state)
            IDLE: if (accept) begin
                nextState = earlyOut ? DONE : RUN;
                writeRes  = earlyOut;
            end
            RUN:  if (count == CW'(WIDTH)) nextState = FIX;
            FIX:  begin
                nextState = DONE;
                writeRes  = 1'b1;
            end
            DONE: nextState = IDLE;
        endcase
        if (flush) begin
            nextState = IDLE;
            writeRes  = 1'b0;
        end
    end

    // One iteration of each algorithm on the shared {hi,lo} accumulator.
    logic [WIDTH:0]     mulSum, remShift, remDiff;
    logic [2*WIDTH-1:0] mulStep, divStep;

    assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                    + (acc[0] ? {1'b0, bMag} : '0);
    assign mulStep  = {mulSum, acc[WIDTH-1:1]};
    assign remShift = acc[2*WIDTH-1:WIDTH-1];
    assign remDiff  = remShift - {1'b0, bMag};
    assign divStep  = remDiff[WIDTH]
                    ? {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                    : {remDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    logic               negQ, negR;
    logic [WIDTH-1:0]   quot, rem, resHi, resLo;
    logic [2*WIDTH-1:0] prod;
    logic               resDz;

    assign negQ = signA ^ signB;
    assign negR = signA;
    assign quot = negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem  = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign prod = negQ ? -acc : acc;

    always_comb begin
        resHi = '0;
        resLo = '0;
        resDz = 1'b0;
        if (state == IDLE) begin
            // Early-out only: divides here always have a zero divisor.
            resDz = op[1];
            resHi = op[1] ? operandA : '0;
            resLo = op[1] ? '1 : '0;
        end else if (opReg[1]) begin
            if (bZero) begin
                resDz = 1'b1;
                resHi = aRaw;
                resLo = '1;
            end else begin
                resHi = rem;
                resLo = quot;
            end
        end else begin
            {resHi, resLo} = prod;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opReg     <= '0;
            aMag      <= '0;
            bMag      <= '0;
            aRaw      <= '0;
            signA     <= 1'b0;
            signB     <= 1'b0;
            bZero     <= 1'b0;
            count     <= '0;
            acc       <= '0;
            hiOut     <= '0;
            loOut     <= '0;
            divByZero <= 1'b0;
        end else begin
            if (state == IDLE) begin
                count <= '0;
                if (accept) begin
                    opReg <= op;
                    aMag  <= magA;
                    bMag  <= magB;
                    aRaw  <= operandA;
                    signA <= aNeg;
                    signB <= bNeg;
                    bZero <= (operandB == '0);
                end
            end else if (state == RUN) begin
                // First RUN cycle seeds the accumulator; WIDTH steps follow.
                if (count == '0)   acc <= {{WIDTH{1'b0}}, aMag};
                else if (opReg[1]) acc <= divStep;
                else               acc <= mulStep;
                count <= count + 1'b1;
            end
            if (writeRes) begin
                hiOut     <= resHi;
                loOut     <= resLo;
                divByZero <= resDz;
            end
        end
    end

endmodule

// File: tb/tb_mdlu_sequencer.sv
// tb_mdlu_sequencer: directed plus random checks of mdlu_sequencer against
// a 64-bit arithmetic reference model.
module tb_mdlu_sequencer;

    localparam int W = 32;

    logic          clk, reset, start, flush;
    logic [1:0]    opIn;
    logic [W-1:0]  opA, opB;
    logic          busy, stall, done, hiLoWrite, divByZero;
    logic [W-1:0]  hiOut, loOut;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] lastHi = '0;
    logic [W-1:0] lastLo = '0;
    logic         lastDz = 1'b0;

    mdlu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(opIn),
        .operandA(opA), .operandB(opB), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .hiLoWrite(hiLoWrite),
        .hiOut(hiOut), .loOut(loOut), .divByZero(divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {divByZero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'b00: begin p = sa * sb; return {1'b0, p}; end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            default: begin
                if (b == '0) return {1'b1, a, 32'hFFFF_FFFF};
                if (o == 2'b11) return {1'b0, a % b, a / b};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, 32'(r), 32'(q)};
            end
        endcase
    endfunction

    function automatic int expBusy(input logic [1:0] o,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b);
`ifdef MDSEQ_EARLY_OUT_EN
        if (o[1] ? (b == '0) : (a == '0 || b == '0)) return 0;
`endif
        return W + 2;
    endfunction

    // Called at a negedge with the DUT in IDLE.
    task automatic runOp(input string tag, input logic [1:0] o,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold);
        logic [64:0] e;
        int cycles, busyCnt;
        e = model(o, a, b);
        start = 1'b1; opIn = o; opA = a; opB = b;
        #1;
        check({tag, ".stallAcc"}, 64'(stall), 64'd1);
        check({tag, ".busyIdle"}, 64'(busy), 64'd0);
        @(negedge clk);
        if (!hold) start = 1'b0;
        cycles = 0;
        busyCnt = 0;
        while (done !== 1'b1 && cycles < 100) begin
            if (busy) busyCnt++;
            check({tag, ".stallTrack"}, 64'(stall), 64'(busy));
            @(negedge clk);
            cycles++;
        end
        check({tag, ".doneSeen"}, 64'(cycles < 100), 64'd1);
        check({tag, ".busyCycles"}, 64'(busyCnt), 64'(expBusy(o, a, b)));
        check({tag, ".hiLoWrite"}, 64'(hiLoWrite), 64'd1);
        check({tag, ".hi"}, 64'(hiOut), 64'(e[63:32]));
        check({tag, ".lo"}, 64'(loOut), 64'(e[31:0]));
        check({tag, ".dz"}, 64'(divByZero), 64'(e[64]));
        check({tag, ".stallDone"}, 64'(stall), 64'd0);
        lastHi = e[63:32];
        lastLo = e[31:0];
        lastDz = e[64];
        @(negedge clk);
        check({tag, ".donePulse"}, 64'({done, hiLoWrite}), 64'd0);
        check({tag, ".hiHold"}, 64'(hiOut), 64'(lastHi));
        if (hold) begin
            check({tag, ".stallIdleHeld"}, 64'(stall), 64'd1);
            check({tag, ".noReaccept"}, 64'(busy), 64'd0);
            start = 1'b0;
            @(negedge clk);
            check({tag, ".stillIdle"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0]   ro;
        start = 1'b1; flush = 1'b0; opIn = 2'b01;
        opA = 32'd9; opB = 32'd9;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.hi", 64'(hiOut), 64'd0);
        check("rst.lo", 64'(loOut), 64'd0);
        check("rst.dz", 64'(divByZero), 64'd0);
        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle.busy", 64'(busy), 64'd0);
        check("idle.done", 64'(done), 64'd0);

        runOp("mult", 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
        runOp("divu", 2'b11, 32'd100, 32'd7, 1'b0);
        runOp("div", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        runOp("div0", 2'b10, 32'd5, 32'd0, 1'b0);
        runOp("divNeg0", 2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0);
        runOp("divu0", 2'b11, 32'h8000_0001, 32'd0, 1'b0);
        runOp("multMin", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        runOp("divMin", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        runOp("multuMax", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runOp("multZero", 2'b00, 32'd0, 32'd5, 1'b0);

        // Flush at busy cycle 10 of a MULTU.
        start = 1'b1; opIn = 2'b01; opA = 32'h8000_0000; opB = 32'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("flush.busyBefore", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush.busy", 64'(busy), 64'd0);
        check("flush.done", 64'({done, hiLoWrite}), 64'd0);
        check("flush.hi", 64'(hiOut), 64'(lastHi));
        check("flush.lo", 64'(loOut), 64'(lastLo));
        check("flush.dz", 64'(divByZero), 64'(lastDz));
        runOp("afterFlush", 2'b01, 32'h8000_0000, 32'd2, 1'b0);

        // Flush and start together: not accepted.
        start = 1'b1; flush = 1'b1; opIn = 2'b00; opA = 32'd3; opB = 32'd3;
        #1;
        check("flushStart.stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flushStart.busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("flushStart.noDone", 64'(done), 64'd0);

        runOp("heldStart", 2'b01, 32'd6, 32'd7, 1'b1);

        // Reset in the middle of an operation.
        start = 1'b1; opIn = 2'b10; opA = 32'd1000; opB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midRst.busy", 64'(busy), 64'd0);
        check("midRst.hi", 64'(hiOut), 64'd0);
        check("midRst.lo", 64'(loOut), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        lastHi = '0; lastLo = '0; lastDz = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("midRst.noDone", 64'({done, busy}), 64'd0);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       ra = '0;
                1:       ra = 32'h8000_0000;
                2:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            runOp($sformatf("rand%0d", i), ro, ra, rb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
